// File: rtl/cplx_acc_pkg.sv
// cplx_acc shared definitions: packed-sample field
// positions, sample width, control states, clamp bounds.
package cplx_acc_pkg;

  localparam int RE_MSB = 31;
  localparam int RE_LSB = 16;
  localparam int IM_MSB = 15;
  localparam int IM_LSB = 0;
  localparam int SMP_W  = 16;

  typedef enum logic [1:0] {
    ACC,
    ACC_PEND,
    STALL
  } ctl_e;

  function automatic longint sat_max(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/cplx_sat_add.sv
// One accumulator channel: sign-extends a 16-bit sample,
// adds it to acc, clamps to ACC_W bits and flags a clamp.
// Ports: acc/smp in, sum/sat out (combinational).
module cplx_sat_add
  import cplx_acc_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [SMP_W-1:0] smp,
  output logic signed [ACC_W-1:0] sum,
  output logic                    sat
);

  localparam logic signed [ACC_W:0] MAXV =
    (ACC_W+1)'(sat_max(ACC_W));
  localparam logic signed [ACC_W:0] MINV =
    (ACC_W+1)'(sat_min(ACC_W));

  logic signed [ACC_W:0] wide;

  // One guard bit is enough: |smp| <= 2^15 <= 2^(ACC_W-1).
  always_comb begin
    wide = {acc[ACC_W-1], acc}
         + {{(ACC_W+1-SMP_W){smp[SMP_W-1]}}, smp};
    sum  = wide[ACC_W-1:0];
    sat  = 1'b0;
    priority case (1'b1)
      (wide > MAXV): begin
        sum = MAXV[ACC_W-1:0];
        sat = 1'b1;
      end
      (wide < MINV): begin
        sum = MINV[ACC_W-1:0];
        sat = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cplx_acc.sv
// Frame accumulator for packed complex products: sums LEN
// samples per channel with saturation, one result per frame.
// Ports: clk, rst, clr, in_data/in_valid/in_ready,
// out_re/out_im/out_sat/out_valid/out_ready.
module cplx_acc
  import cplx_acc_pkg::*;
#(
  parameter int LEN   = 16,
  parameter int ACC_W = 24,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic [31:0]             in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [ACC_W-1:0] out_re,
  output logic signed [ACC_W-1:0] out_im,
  output logic                    out_sat,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  logic signed [ACC_W-1:0] acc_re;
  logic signed [ACC_W-1:0] acc_im;
  logic signed [ACC_W-1:0] sum_re;
  logic signed [ACC_W-1:0] sum_im;
  logic                    sat_re;
  logic                    sat_im;
  logic                    sat_q;
  logic [CNT_W-1:0]        cnt;

  ctl_e st_q;
  ctl_e st_d;
  ctl_e mode;

  logic last;
  logic fire;
  logic done;
  logic xfer;

  cplx_sat_add #(.ACC_W(ACC_W)) u_re (
    .acc (acc_re),
    .smp (in_data[RE_MSB:RE_LSB]),
    .sum (sum_re),
    .sat (sat_re)
  );

  cplx_sat_add #(.ACC_W(ACC_W)) u_im (
    .acc (acc_im),
    .smp (in_data[IM_MSB:IM_LSB]),
    .sum (sum_im),
    .sat (sat_im)
  );

  // The register holds ACC or ACC_PEND; STALL is the pending
  // state seen while the frame-closing sample waits on
  // out_ready, so it depends on this cycle's out_ready.
  always_comb begin
    last = (cnt == LAST);
    mode = st_q;
    if (st_q == ACC_PEND && last && !out_ready)
      mode = STALL;
    out_valid = (st_q != ACC);
    in_ready  = !clr && (mode != STALL);
    fire = in_valid && in_ready;
    done = fire && last;
    xfer = out_valid && out_ready;
    st_d = st_q;
    priority case (1'b1)
      done:    st_d = ACC_PEND;
      xfer:    st_d = ACC;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) st_q <= ACC;
    else     st_q <= st_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_re  <= '0;
      acc_im  <= '0;
      sat_q   <= 1'b0;
      cnt     <= '0;
      out_re  <= '0;
      out_im  <= '0;
      out_sat <= 1'b0;
    end else if (clr) begin
      acc_re <= '0;
      acc_im <= '0;
      sat_q  <= 1'b0;
      cnt    <= '0;
    end else if (fire) begin
      if (last) begin
        out_re  <= sum_re;
        out_im  <= sum_im;
        out_sat <= sat_q | sat_re | sat_im;
        acc_re  <= '0;
        acc_im  <= '0;
        sat_q   <= 1'b0;
        cnt     <= '0;
      end else begin
        acc_re <= sum_re;
        acc_im <= sum_im;
        sat_q  <= sat_q | sat_re | sat_im;
        cnt    <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cplx_acc.sv
// Testbench for cplx_acc: two instances (ACC_W 24 and 17)
// share inputs; directed scenarios plus a random model run.
module tb_cplx_acc;

  localparam int LEN = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_data;

  logic        a_rdy, a_valid, a_sat;
  logic [23:0] a_re, a_im;
  logic        b_rdy, b_valid, b_sat;
  logic [16:0] b_re, b_im;

  always #5 clk = ~clk;

  cplx_acc #(.LEN(LEN), .ACC_W(24), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .clr(clr),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(a_rdy),
    .out_re(a_re), .out_im(a_im), .out_sat(a_sat),
    .out_valid(a_valid), .out_ready(out_ready)
  );

  cplx_acc #(.LEN(LEN), .ACC_W(17), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .clr(clr),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(b_rdy),
    .out_re(b_re), .out_im(b_im), .out_sat(b_sat),
    .out_valid(b_valid), .out_ready(out_ready)
  );

  int nvec = 0;
  int nerr = 0;

  bit          m_pend;
  int          m_cnt;
  logic [31:0] q[$];
  logic [23:0] ea_re, ea_im;
  bit          ea_sat;
  logic [16:0] eb_re, eb_im;
  bit          eb_sat;
  bit          m_rdy;
  logic        obs_a_rdy, obs_b_rdy;

  function automatic void frame_sum(input int w,
    output longint re, output longint im, output bit sat);
    longint mx;
    longint mn;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -mx - 1;
    re = 0;
    im = 0;
    sat = 0;
    foreach (q[i]) begin
      re += longint'($signed(q[i][31:16]));
      im += longint'($signed(q[i][15:0]));
      if (re > mx) begin re = mx; sat = 1; end
      if (re < mn) begin re = mn; sat = 1; end
      if (im > mx) begin im = mx; sat = 1; end
      if (im < mn) begin im = mn; sat = 1; end
    end
  endfunction

  task automatic model_reset;
    m_pend = 0;
    m_cnt  = 0;
    q.delete();
    ea_re = '0; ea_im = '0; ea_sat = 0;
    eb_re = '0; eb_im = '0; eb_sat = 0;
  endtask

  task automatic drive_rst;
    @(negedge clk);
    rst = 1; clr = 0; in_valid = 0;
    in_data = '0; out_ready = 1;
    @(posedge clk);
    model_reset();
    #1;
    rst = 0;
  endtask

  task automatic step(input bit v, input logic [31:0] d,
                      input bit c, input bit r);
    bit acc;
    bit xfer;
    bit done;
    longint sr, si;
    bit ss;
    @(negedge clk);
    in_valid = v; in_data = d; clr = c; out_ready = r;
    #1;
    obs_a_rdy = a_rdy;
    obs_b_rdy = b_rdy;
    m_rdy = !c && !(m_pend && !r && m_cnt == LEN - 1);
    @(posedge clk);
    acc  = v && m_rdy;
    xfer = m_pend && r;
    done = 0;
    if (c) begin
      q.delete();
      m_cnt = 0;
    end else if (acc) begin
      q.push_back(d);
      if (m_cnt == LEN - 1) begin
        frame_sum(24, sr, si, ss);
        ea_re = sr[23:0]; ea_im = si[23:0]; ea_sat = ss;
        frame_sum(17, sr, si, ss);
        eb_re = sr[16:0]; eb_im = si[16:0]; eb_sat = ss;
        q.delete();
        m_cnt = 0;
        done = 1;
      end else begin
        m_cnt++;
      end
    end
    if (done) m_pend = 1;
    else if (xfer) m_pend = 0;
    #1;
  endtask

  task automatic test_reset;
    drive_rst();
    nvec++;
    if (a_valid !== 1'b0 || a_re !== 24'h0 ||
        a_im !== 24'h0 || a_sat !== 1'b0 || a_rdy !== 1'b1) begin
      nerr++;
      $display("FAIL reset: valid=%b re=%h im=%h sat=%b rdy=%b want 0 0 0 0 1",
               a_valid, a_re, a_im, a_sat, a_rdy);
    end
  endtask

  task automatic test_basic;
    step(0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      step(1, 32'h0001FFFF, 0, 1);
      if (k == 2) begin
        nvec++;
        if (a_valid !== 1'b0) begin
          nerr++;
          $display("FAIL basic_early: valid=%b want 0", a_valid);
        end
      end
    end
    nvec++;
    if (a_valid !== 1'b1 || a_re !== 24'h000004 ||
        a_im !== 24'hFFFFFC || a_sat !== 1'b0) begin
      nerr++;
      $display("FAIL basic: valid=%b re=%h im=%h sat=%b want 1 000004 fffffc 0",
               a_valid, a_re, a_im, a_sat);
    end
    step(0, 0, 0, 1);
    nvec++;
    if (a_valid !== 1'b0) begin
      nerr++;
      $display("FAIL basic_drop: valid=%b want 0", a_valid);
    end
  endtask

  task automatic test_back_to_back;
    step(0, 0, 0, 1);
    for (int k = 0; k < 4; k++) step(1, 32'h00010001, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, 32'h00020002, 0, 0);
      nvec++;
      if (obs_a_rdy !== 1'b1) begin
        nerr++;
        $display("FAIL bp_accept%0d: in_ready=%b want 1", k, obs_a_rdy);
      end
    end
    step(1, 32'h00020002, 0, 0);
    nvec++;
    if (obs_a_rdy !== 1'b0 || a_valid !== 1'b1 ||
        a_re !== 24'h4 || a_im !== 24'h4) begin
      nerr++;
      $display("FAIL bp_stall: rdy=%b valid=%b re=%h im=%h want 0 1 4 4",
               obs_a_rdy, a_valid, a_re, a_im);
    end
    step(1, 32'h00020002, 0, 1);
    nvec++;
    if (obs_a_rdy !== 1'b1 || a_valid !== 1'b1 ||
        a_re !== 24'h8 || a_im !== 24'h8) begin
      nerr++;
      $display("FAIL bp_release: rdy=%b valid=%b re=%h im=%h want 1 1 8 8",
               obs_a_rdy, a_valid, a_re, a_im);
    end
    step(0, 0, 0, 1);
    nvec++;
    if (a_valid !== 1'b0) begin
      nerr++;
      $display("FAIL bp_drop: valid=%b want 0", a_valid);
    end
  endtask

  task automatic test_saturate;
    step(0, 0, 0, 1);
    for (int k = 0; k < 4; k++) step(1, 32'h7FFF8000, 0, 1);
    nvec++;
    if (b_valid !== 1'b1 || b_re !== 17'h0FFFF ||
        b_im !== 17'h10000 || b_sat !== 1'b1) begin
      nerr++;
      $display("FAIL sat17: valid=%b re=%h im=%h sat=%b want 1 0ffff 10000 1",
               b_valid, b_re, b_im, b_sat);
    end
    nvec++;
    if (a_re !== 24'h01FFFC || a_im !== 24'hFE0000 ||
        a_sat !== 1'b0) begin
      nerr++;
      $display("FAIL sat24: re=%h im=%h sat=%b want 01fffc fe0000 0",
               a_re, a_im, a_sat);
    end
    for (int k = 0; k < 4; k++) step(1, 32'h00010001, 0, 1);
    nvec++;
    if (b_valid !== 1'b1 || b_re !== 17'h4 ||
        b_im !== 17'h4 || b_sat !== 1'b0) begin
      nerr++;
      $display("FAIL sat_clear: valid=%b re=%h im=%h sat=%b want 1 4 4 0",
               b_valid, b_re, b_im, b_sat);
    end
  endtask

  task automatic test_clr;
    step(0, 0, 0, 1);
    step(1, 32'h00050005, 0, 1);
    step(1, 32'h00050005, 0, 1);
    step(1, 32'h00630063, 1, 1);
    nvec++;
    if (obs_a_rdy !== 1'b0) begin
      nerr++;
      $display("FAIL clr_rdy: in_ready=%b want 0", obs_a_rdy);
    end
    for (int k = 0; k < 3; k++) step(1, 32'h00020002, 0, 1);
    nvec++;
    if (a_valid !== 1'b0) begin
      nerr++;
      $display("FAIL clr_early: valid=%b want 0", a_valid);
    end
    step(1, 32'h00020002, 0, 1);
    nvec++;
    if (a_valid !== 1'b1 || a_re !== 24'h8 || a_im !== 24'h8) begin
      nerr++;
      $display("FAIL clr_result: valid=%b re=%h im=%h want 1 8 8",
               a_valid, a_re, a_im);
    end
  endtask

  task automatic test_gaps;
    step(0, 0, 0, 1);
    for (int k = 0; k < 8; k++) begin
      step(k % 2 == 0, 32'hFFFF0001, 0, 1);
      if (k == 5) begin
        nvec++;
        if (a_valid !== 1'b0) begin
          nerr++;
          $display("FAIL gaps_early: valid=%b want 0", a_valid);
        end
      end
      if (k == 6) begin
        nvec++;
        if (a_valid !== 1'b1 || a_re !== 24'hFFFFFC ||
            a_im !== 24'h000004) begin
          nerr++;
          $display("FAIL gaps: valid=%b re=%h im=%h want 1 fffffc 000004",
                   a_valid, a_re, a_im);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    step(0, 0, 0, 1);
    for (int k = 0; k < 6; k++) step(1, 32'h00010001, 0, 0);
    nvec++;
    if (a_valid !== 1'b1) begin
      nerr++;
      $display("FAIL rstmid_pend: valid=%b want 1", a_valid);
    end
    drive_rst();
    nvec++;
    if (a_valid !== 1'b0 || a_re !== 24'h0 || a_im !== 24'h0 ||
        a_sat !== 1'b0 || b_valid !== 1'b0) begin
      nerr++;
      $display("FAIL rstmid_clear: valid=%b re=%h im=%h sat=%b bvalid=%b want 0 0 0 0 0",
               a_valid, a_re, a_im, a_sat, b_valid);
    end
    for (int k = 0; k < 4; k++) step(1, 32'h00030003, 0, 1);
    nvec++;
    if (a_valid !== 1'b1 || a_re !== 24'hC || a_im !== 24'hC) begin
      nerr++;
      $display("FAIL rstmid_fresh: valid=%b re=%h im=%h want 1 c c",
               a_valid, a_re, a_im);
    end
  endtask

  task automatic test_random;
    logic [31:0] d;
    drive_rst();
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 5))
        0:       d = 32'h7FFF7FFF;
        1:       d = 32'h80008000;
        default: d = $urandom;
      endcase
      step($urandom_range(0, 3) != 0, d,
           $urandom_range(0, 31) == 0,
           $urandom_range(0, 2) != 0);
      nvec++;
      if (obs_a_rdy !== m_rdy || obs_b_rdy !== m_rdy ||
          a_valid !== m_pend || b_valid !== m_pend) begin
        nerr++;
        $display("FAIL rand_ctl%0d: rdy=%b/%b valid=%b/%b want rdy=%b valid=%b",
                 n, obs_a_rdy, obs_b_rdy, a_valid, b_valid, m_rdy, m_pend);
      end
      if (m_pend) begin
        nvec++;
        if (a_re !== ea_re || a_im !== ea_im || a_sat !== ea_sat ||
            b_re !== eb_re || b_im !== eb_im || b_sat !== eb_sat) begin
          nerr++;
          $display("FAIL rand_data%0d: a=%h %h %b b=%h %h %b want a=%h %h %b b=%h %h %b",
                   n, a_re, a_im, a_sat, b_re, b_im, b_sat,
                   ea_re, ea_im, ea_sat, eb_re, eb_im, eb_sat);
        end
      end
    end
  endtask

  initial begin
    rst = 1; clr = 0; in_valid = 0;
    in_data = '0; out_ready = 1;
    model_reset();
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturate();
    test_clr();
    test_gaps();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
